// File: rtl/host_msix_monitor.sv
// MSI-X write monitor: snoops host DW writes against a programmable vector table
// and raises sticky per-vector pending bits with saturating hit counters.

module host_msix_vec #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = 2,
  parameter int IDX    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s1_vld,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_en,
  input  logic              clr_valid,
  input  logic [IDX_W-1:0]  clr_idx,
  output logic              pending,
  output logic [CNT_W-1:0]  count,
  output logic              ovf
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              sel_cfg, sel_clr, hit;

  // Out-of-range indices never equal IDX, so they fall through as no-ops.
  assign sel_cfg = cfg_we    && (cfg_idx == IDX_W'(IDX));
  assign sel_clr = clr_valid && (clr_idx == IDX_W'(IDX));
  assign hit     = s1_vld && en && (s1_addr == addr) && (s1_data == data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en   <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (sel_cfg) begin
      en   <= cfg_en;
      addr <= cfg_addr;
      data <= cfg_data;
    end
  end

  // A hit landing on the same edge as a clear wins and restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end else if (hit) begin
      pending <= 1'b1;
      if (sel_clr) begin
        count <= CNT_W'(1);
        ovf   <= 1'b0;
      end else if (&count) begin
        ovf   <= 1'b1;
      end else begin
        count <= count + CNT_W'(1);
      end
    end else if (sel_clr) begin
      pending <= 1'b0;
      count   <= '0;
      ovf     <= 1'b0;
    end
  end
endmodule

module host_msix_monitor #(
  parameter  int NUM_VEC = 4,
  parameter  int ADDR_W  = 64,
  parameter  int DATA_W  = 32,
  parameter  int CNT_W   = 8,
  localparam int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_valid,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [DATA_W-1:0]  cfg_data,
  input  logic               cfg_en,
  input  logic [NUM_VEC-1:0] vec_mask,
  input  logic               clr_valid,
  input  logic [IDX_W-1:0]   clr_idx,
  output logic               clr_ready,
  output logic [NUM_VEC-1:0] intr_pending,
  output logic [NUM_VEC-1:0] intr_out,
  output logic               intr_any,
  input  logic [IDX_W-1:0]   cnt_rd_idx,
  output logic [CNT_W-1:0]   cnt_rd_data,
  output logic               ovf_rd
);
  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t                           s1;
  logic [NUM_VEC-1:0][CNT_W-1:0]   count;
  logic [NUM_VEC-1:0]              ovf;
  logic [CNT_W-1:0]                rd_cnt;
  logic                            rd_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1 <= '0;
    else     s1 <= {wr_valid, wr_addr, wr_data};
  end

  for (genvar v = 0; v < NUM_VEC; v++) begin : g_vec
    host_msix_vec #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .IDX_W(IDX_W), .IDX(v)
    ) u_vec (
      .clk       (clk),
      .rst       (rst),
      .s1_vld    (s1.vld),
      .s1_addr   (s1.addr),
      .s1_data   (s1.data),
      .cfg_we    (cfg_we),
      .cfg_idx   (cfg_idx),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data),
      .cfg_en    (cfg_en),
      .clr_valid (clr_valid),
      .clr_idx   (clr_idx),
      .pending   (intr_pending[v]),
      .count     (count[v]),
      .ovf       (ovf[v])
    );
  end

  assign clr_ready = 1'b1;
  assign intr_out  = intr_pending & ~vec_mask;
  assign intr_any  = |intr_out;

  always_comb begin
    rd_cnt = '0;
    rd_ovf = 1'b0;
    for (int v = 0; v < NUM_VEC; v++) begin
      if (cnt_rd_idx == IDX_W'(v)) begin
        rd_cnt = count[v];
        rd_ovf = ovf[v];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_rd_data <= '0;
      ovf_rd      <= 1'b0;
    end else begin
      cnt_rd_data <= rd_cnt;
      ovf_rd      <= rd_ovf;
    end
  end
endmodule

// File: tb/tb_host_msix_monitor.sv
// Directed bench for host_msix_monitor: table of single-cycle vectors plus
// hand sequences for masking, saturation, clear/hit collision, multi-match and reset.

module tb_host_msix_monitor;
  localparam int NV = 6, AW = 64, DW = 32, CW = 8, IW = 3;

  logic          clk = 1'b0, rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          cfg_we = 1'b0, cfg_en = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [NV-1:0] vec_mask = '0;
  logic          clr_valid = 1'b0;
  logic [IW-1:0] clr_idx = '0;
  logic          clr_ready;
  logic [NV-1:0] intr_pending, intr_out;
  logic          intr_any;
  logic [IW-1:0] cnt_rd_idx = '0;
  logic [CW-1:0] cnt_rd_data;
  logic          ovf_rd;

  int n_vec = 0, n_bad = 0;

  host_msix_monitor #(.NUM_VEC(NV), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_en(cfg_en), .vec_mask(vec_mask), .clr_valid(clr_valid), .clr_idx(clr_idx),
    .clr_ready(clr_ready), .intr_pending(intr_pending), .intr_out(intr_out),
    .intr_any(intr_any), .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data), .ovf_rd(ovf_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NV-1:0] mask;
    logic          cv;
    logic [IW-1:0] ci;
    logic [IW-1:0] ri;
    logic [NV-1:0] e_pend;
    logic [NV-1:0] e_out;
    logic          e_any;
    logic [CW-1:0] e_cnt;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [IW-1:0] i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d; cfg_en = e;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic clr(input logic [IW-1:0] i);
    clr_valid = 1'b1; clr_idx = i;
    step();
    clr_valid = 1'b0;
  endtask

  task automatic clear_all();
    for (int v = 0; v < NV; v++) clr(IW'(v));
  endtask

  initial begin
    // row: wv, addr, data, mask, clr_v, clr_i, rd_idx | pend, out, any, cnt, ovf
    tbl[0]  = '{1'b1, 64'h1,   32'h12345678, 6'h02, 1'b0, 3'd0, 3'd0, 6'h00, 6'h00, 1'b0, 8'd0, 1'b0};
    tbl[1]  = '{1'b0, 64'h0,   32'h0,        6'h02, 1'b0, 3'd0, 3'd0, 6'h01, 6'h01, 1'b1, 8'd0, 1'b0};
    tbl[2]  = '{1'b0, 64'h0,   32'h0,        6'h02, 1'b0, 3'd0, 3'd0, 6'h01, 6'h01, 1'b1, 8'd1, 1'b0};
    tbl[3]  = '{1'b1, 64'h1,   32'h0,        6'h02, 1'b0, 3'd0, 3'd0, 6'h01, 6'h01, 1'b1, 8'd1, 1'b0};
    tbl[4]  = '{1'b1, 64'h2,   32'h12345678, 6'h02, 1'b0, 3'd0, 3'd0, 6'h01, 6'h01, 1'b1, 8'd1, 1'b0};
    tbl[5]  = '{1'b1, 64'h100, 32'hAAAA0001, 6'h02, 1'b0, 3'd0, 3'd0, 6'h01, 6'h01, 1'b1, 8'd1, 1'b0};
    tbl[6]  = '{1'b0, 64'h0,   32'h0,        6'h02, 1'b0, 3'd0, 3'd1, 6'h03, 6'h01, 1'b1, 8'd0, 1'b0};
    tbl[7]  = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b0, 3'd0, 3'd1, 6'h03, 6'h03, 1'b1, 8'd1, 1'b0};
    tbl[8]  = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b1, 3'd0, 3'd0, 6'h02, 6'h02, 1'b1, 8'd1, 1'b0};
    tbl[9]  = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b1, 3'd1, 3'd0, 6'h00, 6'h00, 1'b0, 8'd0, 1'b0};
    tbl[10] = '{1'b1, 64'h200, 32'h22222222, 6'h00, 1'b0, 3'd0, 3'd2, 6'h00, 6'h00, 1'b0, 8'd0, 1'b0};
    tbl[11] = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b1, 3'd7, 3'd2, 6'h04, 6'h04, 1'b1, 8'd0, 1'b0};
    tbl[12] = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b1, 3'd6, 3'd2, 6'h04, 6'h04, 1'b1, 8'd1, 1'b0};
    tbl[13] = '{1'b0, 64'h0,   32'h0,        6'h00, 1'b0, 3'd0, 3'd7, 6'h04, 6'h04, 1'b1, 8'd0, 1'b0};

    // Reset state
    #1;
    chk("rst_pending", 64'(intr_pending), 64'h0);
    chk("rst_out", 64'(intr_out), 64'h0);
    chk("rst_any", 64'(intr_any), 64'h0);
    chk("rst_cnt", 64'(cnt_rd_data), 64'h0);
    chk("rst_ovf", 64'(ovf_rd), 64'h0);
    chk("rst_clr_ready", 64'(clr_ready), 64'h1);
    step(); step();
    rst = 1'b0;
    step();

    cfg(3'd0, 64'h1,   32'h12345678, 1'b1);
    cfg(3'd1, 64'h100, 32'hAAAA0001, 1'b1);
    cfg(3'd2, 64'h200, 32'h22222222, 1'b1);
    cfg(3'd3, 64'h300, 32'h33333333, 1'b1);

    for (int i = 0; i < 14; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].a; wr_data = tbl[i].d;
      vec_mask = tbl[i].mask; clr_valid = tbl[i].cv; clr_idx = tbl[i].ci;
      cnt_rd_idx = tbl[i].ri;
      step();
      chk($sformatf("row%0d_pending", i), 64'(intr_pending), 64'(tbl[i].e_pend));
      chk($sformatf("row%0d_out", i), 64'(intr_out), 64'(tbl[i].e_out));
      chk($sformatf("row%0d_any", i), 64'(intr_any), 64'(tbl[i].e_any));
      chk($sformatf("row%0d_cnt", i), 64'(cnt_rd_data), 64'(tbl[i].e_cnt));
      chk($sformatf("row%0d_ovf", i), 64'(ovf_rd), 64'(tbl[i].e_ovf));
    end
    wr_valid = 1'b0; clr_valid = 1'b0;

    // Masked hit still sets pending; unmasking raises intr_out without a clock edge
    clear_all();
    vec_mask = 6'h02;
    beat(64'h100, 32'hAAAA0001);
    step();
    chk("mask_pending1", 64'(intr_pending[1]), 64'h1);
    chk("mask_out1", 64'(intr_out[1]), 64'h0);
    chk("mask_any", 64'(intr_any), 64'h0);
    vec_mask = 6'h00;
    #1;
    chk("unmask_out1", 64'(intr_out[1]), 64'h1);
    chk("unmask_any", 64'(intr_any), 64'h1);

    // Saturation: 255 hits fill the counter, the 256th sets ovf
    clear_all();
    cnt_rd_idx = 3'd2;
    wr_valid = 1'b1; wr_addr = 64'h200; wr_data = 32'h22222222;
    repeat (255) step();
    wr_valid = 1'b0;
    step();
    step();
    chk("sat255_cnt", 64'(cnt_rd_data), 64'd255);
    chk("sat255_ovf", 64'(ovf_rd), 64'h0);
    beat(64'h200, 32'h22222222);
    step();
    step();
    chk("sat256_cnt", 64'(cnt_rd_data), 64'd255);
    chk("sat256_ovf", 64'(ovf_rd), 64'h1);
    clr(3'd2);
    step();
    chk("satclr_cnt", 64'(cnt_rd_data), 64'd0);
    chk("satclr_ovf", 64'(ovf_rd), 64'h0);
    chk("satclr_pending2", 64'(intr_pending[2]), 64'h0);

    // Clear and hit of entry 3 on the same edge: hit wins, count restarts at 1
    clear_all();
    cnt_rd_idx = 3'd3;
    beat(64'h300, 32'h33333333);
    beat(64'h300, 32'h33333333);
    beat(64'h300, 32'h33333333);
    clr(3'd3);
    chk("collide_pending3", 64'(intr_pending[3]), 64'h1);
    step();
    chk("collide_cnt", 64'(cnt_rd_data), 64'd1);
    chk("collide_ovf", 64'(ovf_rd), 64'h0);

    // Out-of-range cfg write must not touch any entry
    clear_all();
    cfg(3'd7, 64'h500, 32'h5, 1'b1);
    beat(64'h500, 32'h5);
    step();
    chk("cfg_oor_pending", 64'(intr_pending), 64'h0);
    beat(64'h300, 32'h33333333);
    step();
    chk("cfg_oor_e3_intact", 64'(intr_pending), 64'h08);

    // Two identical entries both hit; disabling entry0 on the compare edge uses the old entry
    clear_all();
    cfg(3'd0, 64'h300, 32'h33333333, 1'b1);
    beat(64'h300, 32'h33333333);
    step();
    chk("multi_pending", 64'(intr_pending), 64'h09);
    clr(3'd0); clr(3'd3);
    beat(64'h300, 32'h33333333);
    cfg(3'd0, 64'h300, 32'h33333333, 1'b0);
    chk("cfg_same_cycle_pending", 64'(intr_pending), 64'h09);
    clr(3'd0); clr(3'd3);
    beat(64'h300, 32'h33333333);
    step();
    chk("cfg_disabled_pending", 64'(intr_pending), 64'h08);

    // Reset one cycle after a matching beat: everything clears, beat is dropped
    clear_all();
    cnt_rd_idx = 3'd2;
    beat(64'h200, 32'h22222222);
    rst = 1'b1;
    #1;
    chk("midrst_pending", 64'(intr_pending), 64'h0);
    chk("midrst_out", 64'(intr_out), 64'h0);
    chk("midrst_any", 64'(intr_any), 64'h0);
    chk("midrst_cnt", 64'(cnt_rd_data), 64'h0);
    chk("midrst_ovf", 64'(ovf_rd), 64'h0);
    chk("midrst_clr_ready", 64'(clr_ready), 64'h1);
    step();
    rst = 1'b0;
    step(); step();
    chk("postrst_pending", 64'(intr_pending), 64'h0);
    chk("postrst_any", 64'(intr_any), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/host_msix_monitor.md
HOST_MSIX_MONITOR -- requirements
Module: host_msix_monitor

Interface
REQ-001 SHALL have parameter NUM_VEC, default 4, number of MSI-X vector table entries (1..32).
REQ-002 SHALL have parameter ADDR_W, default 64, host write address width.
REQ-003 SHALL have parameter DATA_W, default 32, host write data width.
REQ-004 SHALL have parameter CNT_W, default 8, per-vector hit counter width.
REQ-005 SHALL have port clk  input  1  sole clock; one clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port wr_valid  input  1  host memory DW write beat valid.
REQ-008 SHALL have port wr_addr  input  ADDR_W  write address.
REQ-009 SHALL have port wr_data  input  DATA_W  write data.
REQ-010 SHALL have port cfg_we  input  1  table entry write strobe.
REQ-011 SHALL have port cfg_idx  input  IDX_W=max(1,$clog2(NUM_VEC))  table entry index.
REQ-012 SHALL have port cfg_addr / cfg_data / cfg_en  input  ADDR_W / DATA_W / 1  entry match address, match data, enable.
REQ-013 SHALL have port vec_mask  input  NUM_VEC  per-vector mask bit.
REQ-014 SHALL have port clr_valid / clr_idx  input  1 / IDX_W  pending-clear request and vector.
REQ-015 SHALL have port clr_ready  output  1  clear accepted this cycle.
REQ-016 SHALL have port intr_pending  output  NUM_VEC  sticky pending bits.
REQ-017 SHALL have port intr_out  output  NUM_VEC  intr_pending & ~vec_mask.
REQ-018 SHALL have port intr_any  output  1  OR of intr_out.
REQ-019 SHALL have port cnt_rd_idx  input  IDX_W; cnt_rd_data  output  CNT_W; ovf_rd  output  1  registered counter/overflow readback.

Function
REQ-020 SHALL register wr_valid/wr_addr/wr_data into a stage-1 register every cycle; wr always accepted, no backpressure.
REQ-021 SHALL compare stage-1 beat against all entries in parallel; entry v hits when stage-1 valid, cfg_en[v]=1, addr and data equal.
REQ-022 SHALL, on a hit of entry v, set intr_pending[v] and increment count[v] on the next edge; beat sampled at edge k -> pending visible after edge k+1.
REQ-023 SHALL apply a hit to every matching entry simultaneously, not only the lowest index.
REQ-024 SHALL set pending regardless of vec_mask; masking only gates intr_out; unmasking a pending vector asserts intr_out combinationally.
REQ-025 SHALL saturate count[v] at 2^CNT_W-1; a hit at saturation sets sticky ovf[v], count holds.
REQ-026 SHALL write entry cfg_idx on edge where cfg_we=1; a compare in the same cycle uses the old entry value.
REQ-027 SHALL ignore cfg_idx and clr_idx values >= NUM_VEC (no state change).
REQ-028 SHALL tie clr_ready=1; clear accepted when clr_valid=1, zeroing pending, count, ovf of clr_idx on that edge.
REQ-029 SHALL, when clear and hit target the same vector on the same edge, give the hit priority: pending=1, count=1, ovf=0.
REQ-030 SHALL update cnt_rd_data/ovf_rd one cycle after cnt_rd_idx is sampled (registered read, 1-cycle latency).
REQ-031 SHALL not set pending on a partial match (address only or data only).

Reset
REQ-032 SHALL, on rst=1, asynchronously clear stage-1 valid, all table entries (cfg_en=0, addr=0, data=0), intr_pending, count, ovf, cnt_rd_data, ovf_rd; intr_out=0, intr_any=0, clr_ready=1.
REQ-033 SHALL discard an in-flight stage-1 beat when rst asserts mid-operation; no hit after rst deasserts from pre-reset beats.

Verification
REQ-034 SHALL cover: entry0={addr 0x1, data 0x12345678, en}, write beat same -> intr_pending[0]=1 two edges later, intr_any=1, count0=1.
REQ-035 SHALL cover: vec_mask[1]=1, hit entry1 -> intr_pending[1]=1, intr_out[1]=0; clear mask -> intr_out[1]=1 same cycle.
REQ-036 SHALL cover: CNT_W=8, 256 hits on entry2 -> cnt_rd_data=255, ovf_rd=1; clr_idx=2 -> count 0, ovf 0, pending 0.
REQ-037 SHALL cover: clear of entry3 on same edge as its hit -> pending=1, count=1.
REQ-038 SHALL cover: entries 0 and 3 programmed identically, one beat -> both pending bits set; cfg_we disabling entry0 same cycle as compare -> entry0 still hits.
REQ-039 SHALL cover: rst asserted one cycle after matching beat -> all outputs 0, no pending after release.
